fixed_point_addsub_pipe: RTL and testbench

Pipelined, multi-lane, saturating signed fixed-point adder/subtractor for the execution stage. It generalises the single-lane Q7.8 add/sub unit in three ways: it has parametrised integer and fraction widths, it has N independent lanes with a per-lane operation select, and it has a selectable saturate/wrap mode. It adds a valid/ready handshake, a two-stage pipeline and sticky per-lane overflow status, and it sits between operand fetch and writeback.

---
 rtl/fixed_point_pkg.sv | 30 +++
 rtl/fixed_point_addsub_lane.sv | 52 +++++
 rtl/fixed_point_addsub_pipe.sv | 117 +++++++++++
 tb/tb_fixed_point_addsub_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point types and helpers for the add/sub execution unit.
// Saturation constants are built wide and sliced to the lane width by users.
package fixed_point_pkg;

  localparam int FX_MAX_W = 64;

  typedef enum logic {
    FX_ADD = 1'b0,
    FX_SUB = 1'b1
  } fx_op_e;

  function automatic int fx_w(int int_w, int frac_w);
    return int_w + frac_w;
  endfunction

  function automatic logic [FX_MAX_W-1:0] fx_max(int w);
    logic [FX_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [FX_MAX_W-1:0] fx_min(int w);
    logic [FX_MAX_W-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_addsub_lane.sv
// Single-lane combinational signed add/sub with saturate or wrap.
// Flags are taken from the final (possibly saturated) word.
module fixed_point_addsub_lane
  import fixed_point_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         op_i,
  input  logic         sat_en_i,
  output logic [W-1:0] res_o,
  output logic         n_o,
  output logic         v_o,
  output logic         z_o
);

  localparam logic [FX_MAX_W-1:0] MAX_F = fx_max(W);
  localparam logic [FX_MAX_W-1:0] MIN_F = fx_min(W);
  localparam logic [W-1:0] MAX_V = MAX_F[W-1:0];
  localparam logic [W-1:0] MIN_V = MIN_F[W-1:0];

  logic [W:0] ae;
  logic [W:0] be;
  logic [W:0] s;
  logic       pos_ovf;
  logic       neg_ovf;

  assign ae = {a_i[W-1], a_i};
  assign be = {b_i[W-1], b_i};
  assign s  = (fx_op_e'(op_i) == FX_SUB) ? ae - be : ae + be;

  // W+1 bit sum out of W-bit range iff its top two bits differ
  assign pos_ovf = ~s[W] & s[W-1];
  assign neg_ovf = s[W] & ~s[W-1];

  always_comb begin
    res_o = s[W-1:0];
    if (sat_en_i) begin
      unique case (1'b1)
        pos_ovf: res_o = MAX_V;
        neg_ovf: res_o = MIN_V;
        default: res_o = s[W-1:0];
      endcase
    end
  end

  assign v_o = pos_ovf | neg_ovf;
  assign n_o = res_o[W-1];
  assign z_o = ~|res_o;

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage multi-lane saturating fixed-point add/sub with valid/ready.
// S1 holds operands, S2 holds results/flags; sticky overflow per lane.
module fixed_point_addsub_pipe
  import fixed_point_pkg::*;
#(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      op,
  input  logic                  sat_en,
  input  logic [LANES*fx_w(INT_W, FRAC_W)-1:0] a,
  input  logic [LANES*fx_w(INT_W, FRAC_W)-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*fx_w(INT_W, FRAC_W)-1:0] result,
  output logic [LANES-1:0]      flag_n,
  output logic [LANES-1:0]      flag_v,
  output logic [LANES-1:0]      flag_z,
  output logic [LANES-1:0]      ovf_sticky,
  input  logic                  clr_sticky
);

  localparam int W = fx_w(INT_W, FRAC_W);

  logic             adv1;
  logic             adv2;
  logic             s1_valid_q;
  logic [LANES*W-1:0] a1_q;
  logic [LANES*W-1:0] b1_q;
  logic [LANES-1:0] op1_q;
  logic             sat1_q;

  logic             s2_valid_q;
  logic [LANES*W-1:0] res_d;
  logic [LANES*W-1:0] res_q;
  logic [LANES-1:0] n_d, v_d, z_d;
  logic [LANES-1:0] n_q, v_q, z_q;
  logic [LANES-1:0] sticky_d;
  logic [LANES-1:0] sticky_q;

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a1_q       <= '0;
      b1_q       <= '0;
      op1_q      <= '0;
      sat1_q     <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        a1_q   <= a;
        b1_q   <= b;
        op1_q  <= op;
        sat1_q <= sat_en;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fixed_point_addsub_lane #(.W(W)) u_lane (
      .a_i      (a1_q[i*W +: W]),
      .b_i      (b1_q[i*W +: W]),
      .op_i     (op1_q[i]),
      .sat_en_i (sat1_q),
      .res_o    (res_d[i*W +: W]),
      .n_o      (n_d[i]),
      .v_o      (v_d[i]),
      .z_o      (z_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      n_q        <= '0;
      v_q        <= '0;
      z_q        <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q <= res_d;
        n_q   <= n_d;
        v_q   <= v_d;
        z_q   <= z_d;
      end
    end
  end

  // Set beats clear when both land on the same edge
  always_comb begin
    sticky_d = sticky_q & ~{LANES{clr_sticky}};
    if (s2_valid_q && out_ready) sticky_d = sticky_d | v_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign out_valid  = s2_valid_q;
  assign result     = res_q;
  assign flag_n     = n_q;
  assign flag_v     = v_q;
  assign flag_z     = z_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Scoreboard bench for fixed_point_addsub_pipe at defaults (Q7.8, 4 lanes).
// Expected beats are modelled with integer arithmetic at acceptance.
module tb_fixed_point_addsub_pipe;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  n;
    logic [3:0]  v;
    logic [3:0]  z;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        sat_en;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [3:0]  flag_n;
  logic [3:0]  flag_v;
  logic [3:0]  flag_z;
  logic [3:0]  ovf_sticky;
  logic        clr_sticky;

  int   errors = 0;
  int   checks = 0;
  int   popped = 0;
  exp_t q[$];
  logic [3:0] exp_sticky = '0;

  fixed_point_addsub_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .sat_en     (sat_en),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_n     (flag_n),
    .flag_v     (flag_v),
    .flag_z     (flag_z),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [63:0] ma, logic [63:0] mb,
                                 logic [3:0] mop, logic msat);
    exp_t e;
    int sa, sb, s;
    logic v;
    logic [15:0] r;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      sa = int'($signed(ma[i*16 +: 16]));
      sb = int'($signed(mb[i*16 +: 16]));
      s  = mop[i] ? sa - sb : sa + sb;
      v  = (s > 32767) || (s < -32768);
      if (v && msat) r = (s > 0) ? 16'h7FFF : 16'h8000;
      else           r = s[15:0];
      e.res[i*16 +: 16] = r;
      e.n[i] = r[15];
      e.v[i] = v;
      e.z[i] = (r == 16'h0);
    end
    return e;
  endfunction

  // Mid-cycle monitor: checks output vs queue head, in_ready, sticky
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_sticky = '0;
    end else begin
      chk("sticky", 64'(ovf_sticky), 64'(exp_sticky));
      chk("in_ready", 64'(in_ready),
          64'(!(q.size() == 2 && !out_ready)));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious", 64'(out_valid), 64'h0);
        end else begin
          chk("result", result, q[0].res);
          chk("flags", {52'h0, flag_n, flag_v, flag_z},
              {52'h0, q[0].n, q[0].v, q[0].z});
        end
      end
      exp_sticky = exp_sticky & ~{4{clr_sticky}};
      if (out_valid && out_ready && q.size() > 0) begin
        exp_sticky = exp_sticky | q[0].v;
        void'(q.pop_front());
        popped++;
      end
      if (in_valid && in_ready) q.push_back(model(a, b, op, sat_en));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(logic [63:0] sa, logic [63:0] sb,
                          logic [3:0] sop, logic ssat);
    a = sa; b = sb; op = sop; sat_en = ssat;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] pat;
    int sent;
    int budget;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; sat_en = 1'b0;
    a = '0; b = '0; out_ready = 1'b1; clr_sticky = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_result", result, 64'h0);
    chk("rst_flags", {52'h0, flag_n, flag_v, flag_z}, 64'h0);
    chk("rst_sticky", 64'(ovf_sticky), 64'h0);
    rst_n = 1'b1;
    tick();

    // Saturating overflow on lane 0, latency check
    send_one(64'h0000_0000_0000_7F00, 64'h0000_0000_0000_0200, 4'b0000, 1'b1);
    tick();
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'h1);
    chk("sat_res", 64'(result[15:0]), 64'h7FFF);
    chk("sat_nvz", {61'h0, flag_n[0], flag_v[0], flag_z[0]}, 64'b010);
    tick();
    @(negedge clk);
    chk("sat_sticky0", 64'(ovf_sticky[0]), 64'h1);

    // Wrap mode, same operands
    send_one(64'h0000_0000_0000_7F00, 64'h0000_0000_0000_0200, 4'b0000, 1'b0);
    tick();
    @(negedge clk);
    chk("wrap_res", 64'(result[15:0]), 64'h8100);
    chk("wrap_nv", {62'h0, flag_n[0], flag_v[0]}, 64'b11);
    tick();

    // Mixed lanes
    send_one(64'h8000_0100_0180_1234, 64'h0100_0100_0300_0111, 4'b1110, 1'b1);
    tick();
    @(negedge clk);
    chk("mix_l1", 64'(result[31:16]), 64'hFE80);
    chk("mix_l1_nv", {62'h0, flag_n[1], flag_v[1]}, 64'b10);
    chk("mix_l2", {47'h0, result[47:32], flag_z[2]}, 64'h1);
    chk("mix_l3", {47'h0, result[63:48], flag_v[3]}, {47'h0, 16'h8000, 1'b1});
    tick();

    // Back-to-back with out_ready pattern 1,0,0,1
    pat = 4'b1001;
    sent = 0;
    popped = 0;
    budget = 0;
    while ((sent < 8 || q.size() > 0) && budget < 200) begin
      out_ready = pat[3 - (budget % 4)];
      if (sent < 8) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op = 4'($urandom);
        sat_en = 1'($urandom);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      budget++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("b2b_timeout", 64'(budget < 200), 64'h1);
    chk("b2b_count", 64'(popped), 64'd8);

    // Sticky: plain clear, then clear colliding with an overflow transfer
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("clr_plain", 64'(ovf_sticky), 64'h0);
    send_one(64'h0000_0000_0000_7F00, 64'h0000_0000_0000_0200, 4'b0000, 1'b1);
    tick();
    clr_sticky = 1'b1;
    tick();
    @(negedge clk);
    chk("clr_collide", 64'(ovf_sticky[0]), 64'h1);
    tick();
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("clr_after", 64'(ovf_sticky[0]), 64'h0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op = 4'($urandom);
      sat_en = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    clr_sticky = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("drain", 64'(q.size()), 64'h0);

    // Reset with both stages full
    out_ready = 1'b0;
    send_one(64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404, 4'b0101, 1'b1);
    send_one(64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, 4'b0000, 1'b1);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'h0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_result", result, 64'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'h1);
    repeat (5) tick();
    chk("post_rst_none", 64'(q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
